// File: rtl/prewish_switch_poller_pkg.sv
// Shared types and constants for the switch poller and the stages around it.
// Holds the status byte width, the request payload and the short-period simulation settings.
package prewish_switch_poller_pkg;

   localparam int STATUS_W = 8;

   typedef logic [STATUS_W-1:0] status_t;

   // The debouncer ignores the request payload; it is held at zero.
   localparam status_t REQ_DAT = '0;

   localparam int SIM_POLL_PERIOD = 37;
   localparam int SIM_POLL_BITS   = 6;

   function automatic status_t rising_bits(input status_t cur, input status_t prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/prewish_switch_poller_if.sv
// Request/response strobe handshake between the poller (master) and the debouncer (slave).
interface prewish_switch_poller_if;
   import prewish_switch_poller_pkg::*;

   logic    req_stb;
   status_t req_dat;
   logic    rsp_stb;
   status_t rsp_dat;

   modport master (
      output req_stb,
      output req_dat,
      input  rsp_stb,
      input  rsp_dat
   );

   modport slave (
      input  req_stb,
      input  req_dat,
      output rsp_stb,
      output rsp_dat
   );

endinterface

// File: rtl/prewish_switch_poller_poll_timer.sv
// Free-running down-counter that emits a one-cycle tick every PERIOD cycles.
// Reusable by any stage that polls on a fixed schedule.
module prewish_poll_timer #(
   parameter int PERIOD = 120000,
   parameter int BITS   = 17
) (
   input  logic CLK_I,
   input  logic RST_I,
   output logic o_tick
);

   localparam logic [BITS-1:0] RELOAD = BITS'(PERIOD - 1);

   logic [BITS-1:0] cnt;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         cnt <= RELOAD;
      end else if (cnt == '0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign o_tick = (cnt == '0);

endmodule

// File: rtl/prewish_switch_poller.sv
// Polls the debounced switch byte, turns rising edges into toggles of a blink mask,
// and flags a lost response with a sticky error.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for the poll tick; late or stray responses are ignored
//   REQ    | request strobe high for this single cycle, timeout counter cleared
//   WAIT   | waiting for the response strobe, bounded by TIMEOUT cycles
//   UPDATE | edge detect on the captured byte, mask toggle, update strobe
module prewish_switch_poller
   import prewish_switch_poller_pkg::*;
#(
   parameter int POLL_PERIOD  = 120000,
   parameter int POLL_BITS    = 17,
   parameter int TIMEOUT      = 255,
   parameter int TIMEOUT_BITS = 8
) (
   input  logic                     CLK_I,
   input  logic                     RST_I,
   prewish_switch_poller_if.master  bus,
   output status_t                  o_mask,
   output logic                     o_mask_stb,
   output status_t                  o_press,
   output logic                     o_err,
   output logic                     o_alive
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   localparam logic [TIMEOUT_BITS-1:0] CTR_LIMIT = TIMEOUT_BITS'(TIMEOUT - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic                    tick;

   logic                    stb;
   logic [TIMEOUT_BITS-1:0] ctr;
   status_t                 cap;
   status_t                 prev;
   status_t                 mask;
   logic                    mask_stb;
   status_t                 press;
   logic                    err;
   logic                    alive;

   logic                    stb_d;
   logic [TIMEOUT_BITS-1:0] ctr_d;
   status_t                 cap_d;
   status_t                 prev_d;
   status_t                 mask_d;
   logic                    mask_stb_d;
   status_t                 press_d;
   logic                    err_d;
   logic                    alive_d;
   status_t                 press_w;

   prewish_poll_timer #(
      .PERIOD (POLL_PERIOD),
      .BITS   (POLL_BITS)
   ) u_poll_timer (
      .CLK_I  (CLK_I),
      .RST_I  (RST_I),
      .o_tick (tick)
   );

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state    <= ST_IDLE;
         stb      <= 1'b0;
         ctr      <= '0;
         cap      <= '0;
         prev     <= '0;
         mask     <= '0;
         mask_stb <= 1'b0;
         press    <= '0;
         err      <= 1'b0;
         alive    <= 1'b0;
      end else begin
         state    <= state_nxt;
         stb      <= stb_d;
         ctr      <= ctr_d;
         cap      <= cap_d;
         prev     <= prev_d;
         mask     <= mask_d;
         mask_stb <= mask_stb_d;
         press    <= press_d;
         err      <= err_d;
         alive    <= alive_d;
      end
   end

   // A tick that lands outside IDLE is simply lost; the next one restarts the poll.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (tick) state_nxt = ST_REQ;
         ST_REQ:    state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (bus.rsp_stb) begin
               state_nxt = ST_UPDATE;
            end else if (ctr == CTR_LIMIT) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_UPDATE: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // The response strobe is checked before the limit so a last-cycle answer still counts.
   always_comb begin
      stb_d      = (state_nxt == ST_REQ);
      ctr_d      = ctr;
      cap_d      = cap;
      prev_d     = prev;
      mask_d     = mask;
      mask_stb_d = 1'b0;
      press_d    = '0;
      err_d      = err;
      alive_d    = alive;
      press_w    = rising_bits(cap, prev);
      case (state)
         ST_REQ: begin
            ctr_d = '0;
         end
         ST_WAIT: begin
            if (bus.rsp_stb) begin
               cap_d = bus.rsp_dat;
            end else if (ctr == CTR_LIMIT) begin
               err_d = 1'b1;
            end else begin
               ctr_d = ctr + 1'b1;
            end
         end
         ST_UPDATE: begin
            prev_d  = cap;
            mask_d  = mask ^ press_w;
            alive_d = ~alive;
            if (press_w != '0) begin
               mask_stb_d = 1'b1;
               press_d    = press_w;
            end
         end
         default: ;
      endcase
   end

   assign bus.req_stb = stb;
   assign bus.req_dat = REQ_DAT;
   assign o_mask      = mask;
   assign o_mask_stb  = mask_stb;
   assign o_press     = press;
   assign o_err       = err;
   assign o_alive     = alive;

endmodule
